// File: rtl/traffic_phase_timer.sv
// Two-road intersection phase timer: NS/EW green, yellow and all-red phases
// with selectable green length, emergency shortening and a pedestrian walk flag.
module traffic_phase_timer #(
  parameter int T_DAY    = 30,
  parameter int T_NIGHT  = 15,
  parameter int T_PED    = 45,
  parameter int T_EMERG  = 5,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] loadMaxTimeSelect,
  output logic [2:0] nsLight,
  output logic [2:0] ewLight,
  output logic       walk,
  output logic [5:0] timeLeft,
  output logic       phaseDone
);

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALLRED_A  = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] ALLRED_B  = 3'd5;

  // Lamp encoding is one-hot {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // All lengths are expected to lie in 1..63 so they fit the 6-bit counter.
  localparam logic [5:0] LEN_DAY    = 6'(T_DAY);
  localparam logic [5:0] LEN_NIGHT  = 6'(T_NIGHT);
  localparam logic [5:0] LEN_PED    = 6'(T_PED);
  localparam logic [5:0] LEN_EMERG  = 6'(T_EMERG);
  localparam logic [5:0] LEN_YELLOW = 6'(T_YELLOW);
  localparam logic [5:0] LEN_ALLRED = 6'(T_ALLRED);

  logic [2:0] stateReg, stateNext;
  logic [5:0] timeLeftReg, timeLeftNext;
  logic       walkReg, walkNext;
  logic       phaseDoneReg, phaseDoneNext;
  logic [2:0] nsLightReg, nsLightNext;
  logic [2:0] ewLightReg, ewLightNext;

  logic [5:0] greenLen;
  logic       pedSelect;
  logic       inGreen;
  logic       clampHit;
  logic       phaseEnd;

  function automatic logic [2:0] successor(input logic [2:0] s);
    case (s)
      NS_GREEN:  successor = NS_YELLOW;
      NS_YELLOW: successor = ALLRED_A;
      ALLRED_A:  successor = EW_GREEN;
      EW_GREEN:  successor = EW_YELLOW;
      EW_YELLOW: successor = ALLRED_B;
      default:   successor = NS_GREEN;
    endcase
  endfunction

  function automatic logic [2:0] nsLamp(input logic [2:0] s);
    case (s)
      NS_GREEN:  nsLamp = LAMP_GREEN;
      NS_YELLOW: nsLamp = LAMP_YELLOW;
      default:   nsLamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ewLamp(input logic [2:0] s);
    case (s)
      EW_GREEN:  ewLamp = LAMP_GREEN;
      EW_YELLOW: ewLamp = LAMP_YELLOW;
      default:   ewLamp = LAMP_RED;
    endcase
  endfunction

  // Highest set select bit wins; an empty select falls back to day timing.
  always_comb begin
    greenLen = LEN_DAY;
    if (loadMaxTimeSelect[3])      greenLen = LEN_EMERG;
    else if (loadMaxTimeSelect[2]) greenLen = LEN_PED;
    else if (loadMaxTimeSelect[1]) greenLen = LEN_NIGHT;
    else                           greenLen = LEN_DAY;
  end

  assign pedSelect = !loadMaxTimeSelect[3] && loadMaxTimeSelect[2];
  assign inGreen   = (stateReg == NS_GREEN) || (stateReg == EW_GREEN);
  assign clampHit  = inGreen && loadMaxTimeSelect[3] && (timeLeftReg > LEN_EMERG);
  assign phaseEnd  = tick && (timeLeftReg <= 6'd1);

  always_comb begin
    stateNext     = stateReg;
    timeLeftNext  = timeLeftReg;
    walkNext      = walkReg;
    phaseDoneNext = 1'b0;
    if (phaseEnd) begin
      stateNext     = successor(stateReg);
      phaseDoneNext = 1'b1;
      walkNext      = (stateNext == EW_GREEN) && pedSelect;
      case (stateNext)
        NS_GREEN, EW_GREEN:   timeLeftNext = greenLen;
        NS_YELLOW, EW_YELLOW: timeLeftNext = LEN_YELLOW;
        default:              timeLeftNext = LEN_ALLRED;
      endcase
    end else if (clampHit) begin
      // Emergency shortening acts immediately, without waiting for a tick.
      timeLeftNext = LEN_EMERG;
      walkNext     = 1'b0;
    end else if (tick) begin
      timeLeftNext = timeLeftReg - 6'd1;
    end
  end

  // Lamps are decoded from the next state so they change on the same edge.
  always_comb begin
    nsLightNext = nsLamp(stateNext);
    ewLightNext = ewLamp(stateNext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= ALLRED_B;
      timeLeftReg  <= LEN_ALLRED;
      walkReg      <= 1'b0;
      phaseDoneReg <= 1'b0;
      nsLightReg   <= LAMP_RED;
      ewLightReg   <= LAMP_RED;
    end else begin
      stateReg     <= stateNext;
      timeLeftReg  <= timeLeftNext;
      walkReg      <= walkNext;
      phaseDoneReg <= phaseDoneNext;
      nsLightReg   <= nsLightNext;
      ewLightReg   <= ewLightNext;
    end
  end

  assign nsLight   = nsLightReg;
  assign ewLight   = ewLightReg;
  assign walk      = walkReg;
  assign timeLeft  = timeLeftReg;
  assign phaseDone = phaseDoneReg;

endmodule

// File: doc/traffic_phase_timer.md
TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 Parameter T_DAY, default 30, green length in ticks when day time is selected.
REQ-002 Parameter T_NIGHT, default 15, green length in ticks when night time is selected.
REQ-003 Parameter T_PED, default 45, green length in ticks when pedestrian time is selected.
REQ-004 Parameter T_EMERG, default 5, maximum remaining green in ticks under emergency.
REQ-005 Parameter T_YELLOW, default 4, yellow length in ticks.
REQ-006 Parameter T_ALLRED, default 2, all-red clearance length in ticks; every parameter SHALL be in the range 1..63.
REQ-007 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 tick  input  1  one-cycle time-base enable; timing advances only on cycles with tick=1.
REQ-010 loadMaxTimeSelect  input  4  one-hot max-time select from the upstream priority arbiter: bit3 emergency, bit2 pedestrian, bit1 night, bit0 day.
REQ-011 nsLight  output  3  north-south lamp, one-hot {red,yellow,green}.
REQ-012 ewLight  output  3  east-west lamp, one-hot {red,yellow,green}.
REQ-013 walk  output  1  pedestrian walk indication.
REQ-014 timeLeft  output  6  ticks remaining in the current phase.
REQ-015 phaseDone  output  1  one-cycle pulse on every phase transition.

Function
REQ-016 The FSM SHALL have six states in a fixed cycle: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN.
REQ-017 Lamps SHALL be: NS_GREEN ns=G/ew=R; NS_YELLOW ns=Y/ew=R; EW_GREEN ns=R/ew=G; EW_YELLOW ns=R/ew=Y; both ALLRED states ns=R/ew=R; green and yellow SHALL never appear on both roads at once.
REQ-018 Phase length SHALL be resolved on the transition cycle into a green state, from loadMaxTimeSelect: bit3 -> T_EMERG, bit2 -> T_PED, bit1 -> T_NIGHT, bit0 -> T_DAY.
REQ-019 If loadMaxTimeSelect is multi-hot, the highest set bit SHALL win; if it is all zero, T_DAY SHALL be used.
REQ-020 On entry to a yellow state, timeLeft SHALL load T_YELLOW; on entry to an ALLRED state, it SHALL load T_ALLRED.
REQ-021 On a tick cycle with timeLeft>1, timeLeft SHALL decrement by 1; on a tick cycle with timeLeft<=1, the FSM SHALL advance, load the next phase length, and pulse phaseDone in the following cycle; each phase therefore lasts exactly N ticks.
REQ-022 With tick=0, state and timeLeft SHALL hold.
REQ-023 During either green state, when loadMaxTimeSelect[3]=1 and timeLeft>T_EMERG, timeLeft SHALL be clamped to T_EMERG on that cycle (no tick is required), and the clamp SHALL take priority over decrement; yellow and ALLRED states SHALL never be shortened.
REQ-024 walk SHALL be 1 only during EW_GREEN when that green was loaded via pedestrian select, and SHALL drop on the cycle EW_GREEN exits or an emergency clamp occurs.
REQ-025 The lamp outputs, walk, timeLeft, and phaseDone SHALL all be registered; latency from a tick to a visible output change SHALL be 1 cycle.

Reset
REQ-026 While reset=1, state SHALL be ALLRED_B, nsLight=100, ewLight=100, walk=0, timeLeft=T_ALLRED, phaseDone=0, with tick ignored.
REQ-027 Reset asserted mid-phase SHALL abort the phase on the next edge, with no yellow emitted.
REQ-028 After reset release, the first green SHALL be NS_GREEN, entered after T_ALLRED ticks.

Verification
REQ-029 Reset, then select=0001 with continuous tick -> after 2 ticks, NS_GREEN with timeLeft=30; then 30 ticks of green, 4 of yellow, and 2 of all-red before EW_GREEN; phaseDone pulses once per transition.
REQ-030 select=0010 at NS_GREEN entry -> timeLeft=15; a later select change during the green SHALL NOT alter the length.
REQ-031 select=0100 at EW_GREEN entry -> walk=1 for 45 ticks, then 0 on entry to EW_YELLOW.
REQ-032 EW_GREEN at timeLeft=20 with pedestrian walk active, then select=1000 -> next cycle timeLeft=5 and walk=0; at timeLeft=3, select=1000 -> no change.
REQ-033 select=1000 during NS_YELLOW at timeLeft=4 -> yellow completes all 4 ticks.
REQ-034 tick held 0 for 100 cycles mid-phase -> state and timeLeft unchanged; reset pulse mid-EW_GREEN -> next cycle both lamps red and timeLeft=2.
